// File: rtl/colour_puzzle_pkg.sv
// Shared constants for the colour puzzle stage: palette, colour index width, OLED geometry.
package colour_puzzle_pkg;

    localparam int unsigned COLOUR_W    = 3;
    localparam int unsigned OLED_W      = 96;
    localparam int unsigned OLED_H      = 64;
    localparam int unsigned OLED_PIXELS = 6144;

    typedef enum logic [COLOUR_W-1:0] {
        C_WHITE   = 3'd0,
        C_RED     = 3'd1,
        C_GREEN   = 3'd2,
        C_BLUE    = 3'd3,
        C_YELLOW  = 3'd4,
        C_CYAN    = 3'd5,
        C_MAGENTA = 3'd6,
        C_ORANGE  = 3'd7
    } colour_e;

    // RGB565 palette entries
    localparam logic [15:0] PAL_WHITE   = 16'hFFFF;
    localparam logic [15:0] PAL_RED     = 16'hF800;
    localparam logic [15:0] PAL_GREEN   = 16'h07E0;
    localparam logic [15:0] PAL_BLUE    = 16'h001F;
    localparam logic [15:0] PAL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] PAL_CYAN    = 16'h07FF;
    localparam logic [15:0] PAL_MAGENTA = 16'hF81F;
    localparam logic [15:0] PAL_ORANGE  = 16'hFD20;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] RED    = PAL_RED;
    localparam logic [15:0] YELLOW = PAL_YELLOW;

    function automatic logic [15:0] palette_rgb(input logic [COLOUR_W-1:0] idx);
        logic [15:0] rgb;
        case (idx)
            C_WHITE:   rgb = PAL_WHITE;
            C_RED:     rgb = PAL_RED;
            C_GREEN:   rgb = PAL_GREEN;
            C_BLUE:    rgb = PAL_BLUE;
            C_YELLOW:  rgb = PAL_YELLOW;
            C_CYAN:    rgb = PAL_CYAN;
            C_MAGENTA: rgb = PAL_MAGENTA;
            default:   rgb = PAL_ORANGE;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/blink_divider.sv
// Blink phase generator: phase toggles every BLINK_DIV enabled cycles; clear restarts with phase high.
module blink_divider #(
    parameter int unsigned BLINK_DIV = 16_666_667
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             phase_q, phase_d;

    if (BLINK_DIV < 1) begin : g_bad_div
        $error("blink_divider: BLINK_DIV must be at least 1");
    end

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (clear) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (enable) begin
            if (count_q == CNT_W'(BLINK_DIV - 1)) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/colour_puzzle_panel.sv
// Colour-matching puzzle stage: cursor/colour editing, OLED square rendering, blink/steady LEDs.
// Optional macro COLOUR_PUZZLE_LOCK_EN freezes colour edits once the puzzle is solved.
module colour_puzzle_panel
    import colour_puzzle_pkg::*;
#(
    parameter int unsigned                      NUM_SQUARES = 3,
    parameter int unsigned                      NUM_COLOURS = 4,
    parameter logic [NUM_SQUARES*COLOUR_W-1:0]  TARGET      = {3'd2, 3'd2, 3'd2},
    parameter int unsigned                      SQ_X0       = 43,
    parameter int unsigned                      SQ_Y0       = 5,
    parameter int unsigned                      SQ_SIZE     = 10,
    parameter int unsigned                      SQ_PITCH    = 15,
    parameter int unsigned                      BLINK_DIV   = 16_666_667,
    parameter logic [15:0]                      BLINK_MASK  = 16'h0265,
    parameter logic [15:0]                      STEADY_MASK = 16'h2000
) (
    input  logic        clock_100mhz,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        btn_up,
    input  logic        btn_centre,
    input  logic        btn_down,
    input  logic [12:0] pixel_index,
    output logic [15:0] oled_data,
    output logic [15:0] led,
    output logic        solved
);

    localparam int unsigned CUR_W    = (NUM_SQUARES > 1) ? $clog2(NUM_SQUARES) : 1;
    localparam int unsigned COL_BITS = NUM_SQUARES * COLOUR_W;

    if (NUM_SQUARES < 1 || NUM_SQUARES > 8) begin : g_bad_squares
        $error("colour_puzzle_panel: NUM_SQUARES must be 1..8");
    end
    if (NUM_COLOURS < 2 || NUM_COLOURS > 8) begin : g_bad_colours
        $error("colour_puzzle_panel: NUM_COLOURS must be 2..8");
    end
    if (SQ_Y0 + NUM_SQUARES * SQ_PITCH + SQ_SIZE > OLED_H) begin : g_bad_geometry
        $error("colour_puzzle_panel: squares do not fit the display height");
    end

    logic                enable_q, up_q, centre_q, down_q;
    logic [COL_BITS-1:0] colour_q, colour_d;
    logic [CUR_W-1:0]    cursor_q, cursor_d;
    logic                solved_q, solved_d;
    logic [15:0]         led_q, led_d;
    logic [15:0]         oled_q, oled_d;

    logic                entry, up_evt, down_evt, centre_evt, centre_ok, phase;
    logic [COLOUR_W-1:0] cur_colour, next_colour;
    int unsigned         pix, px_x, px_y, sq_top;
    logic                in_sq, on_ring;
    logic [15:0]         pix_rgb;

    assign entry      = enable & ~enable_q;
    assign up_evt     = enable & btn_up     & ~up_q;
    assign down_evt   = enable & btn_down   & ~down_q;
    assign centre_evt = enable & btn_centre & ~centre_q;

`ifdef COLOUR_PUZZLE_LOCK_EN
    assign centre_ok = ~solved_q;
`else
    assign centre_ok = 1'b1;
`endif

    // Colour edit uses the pre-move cursor; opposing moves cancel.
    always_comb begin
        colour_d    = colour_q;
        cursor_d    = cursor_q;
        cur_colour  = colour_q[cursor_q * COLOUR_W +: COLOUR_W];
        next_colour = (cur_colour == COLOUR_W'(NUM_COLOURS - 1)) ? '0 : cur_colour + COLOUR_W'(1);
        if (entry) begin
            colour_d = '0;
            cursor_d = '0;
        end else begin
            if (centre_evt && centre_ok) begin
                colour_d[cursor_q * COLOUR_W +: COLOUR_W] = next_colour;
            end
            if (up_evt && !down_evt) begin
                cursor_d = (cursor_q == '0) ? CUR_W'(NUM_SQUARES - 1) : cursor_q - CUR_W'(1);
            end else if (down_evt && !up_evt) begin
                cursor_d = (cursor_q == CUR_W'(NUM_SQUARES - 1)) ? '0 : cursor_q + CUR_W'(1);
            end
        end
    end

    always_comb begin
        solved_d = enable & (colour_q == TARGET);
        led_d    = '0;
        if (enable) begin
            led_d = (BLINK_MASK & {16{phase}}) | STEADY_MASK | {solved_d, 15'b0};
        end
    end

    always_comb begin
        pix     = 32'(pixel_index);
        px_x    = pix % OLED_W;
        px_y    = pix / OLED_W;
        pix_rgb = BLACK;
        sq_top  = SQ_Y0;
        in_sq   = 1'b0;
        on_ring = 1'b0;
        for (int unsigned i = 0; i < NUM_SQUARES; i++) begin
            sq_top  = SQ_Y0 + i * SQ_PITCH;
            in_sq   = (px_x >= SQ_X0) && (px_x < SQ_X0 + SQ_SIZE) &&
                      (px_y >= sq_top) && (px_y < sq_top + SQ_SIZE);
            on_ring = (px_x == SQ_X0) || (px_x == SQ_X0 + SQ_SIZE - 1) ||
                      (px_y == sq_top) || (px_y == sq_top + SQ_SIZE - 1);
            if (in_sq) begin
                if (on_ring && i == 32'(cursor_q)) begin
                    pix_rgb = YELLOW;
                end else begin
                    pix_rgb = palette_rgb(colour_q[i * COLOUR_W +: COLOUR_W]);
                end
            end
        end
        sq_top = SQ_Y0 + NUM_SQUARES * SQ_PITCH;
        if ((px_x >= SQ_X0) && (px_x < SQ_X0 + SQ_SIZE) &&
            (px_y >= sq_top) && (px_y < sq_top + SQ_SIZE)) begin
            pix_rgb = solved_q ? palette_rgb(C_RED) : palette_rgb(C_WHITE);
        end
        if (pix >= OLED_PIXELS) begin
            pix_rgb = BLACK;
        end
        oled_d = enable ? pix_rgb : '0;
    end

    blink_divider #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk    (clock_100mhz),
        .rst_n  (reset_n),
        .clear  (entry),
        .enable (enable),
        .phase  (phase)
    );

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            up_q     <= 1'b0;
            centre_q <= 1'b0;
            down_q   <= 1'b0;
            colour_q <= '0;
            cursor_q <= '0;
            solved_q <= 1'b0;
            led_q    <= '0;
            oled_q   <= '0;
        end else begin
            enable_q <= enable;
            up_q     <= btn_up;
            centre_q <= btn_centre;
            down_q   <= btn_down;
            colour_q <= colour_d;
            cursor_q <= cursor_d;
            solved_q <= solved_d;
            led_q    <= led_d;
            oled_q   <= oled_d;
        end
    end

    assign oled_data = oled_q;
    assign led       = led_q;
    assign solved    = solved_q;

endmodule

// File: tb/tb_colour_puzzle_panel.sv
// Self-checking bench for colour_puzzle_panel: per-cycle reference model plus directed literal checks.
module tb_colour_puzzle_panel;

    localparam int NS       = 3;
    localparam int NC       = 4;
    localparam int DIV      = 4;
    localparam int SQ_X0    = 43;
    localparam int SQ_Y0    = 5;
    localparam int SQ_SIZE  = 10;
    localparam int SQ_PITCH = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        btn_up = 1'b0, btn_centre = 1'b0, btn_down = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [15:0] oled_data, led;
    logic        solved;

    int n_checks = 0;
    int n_fail   = 0;

    colour_puzzle_panel #(
        .NUM_SQUARES (NS),
        .NUM_COLOURS (NC),
        .BLINK_DIV   (DIV)
    ) dut (
        .clock_100mhz (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .btn_up       (btn_up),
        .btn_centre   (btn_centre),
        .btn_down     (btn_down),
        .pixel_index  (pixel_index),
        .oled_data    (oled_data),
        .led          (led),
        .solved       (solved)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int m_col [NS];
    int m_cur;
    int m_cnt;
    bit m_ph;
    bit m_solved;
    bit m_en_prev, m_up_prev, m_ce_prev, m_dn_prev;
    logic [15:0] e_oled, e_led;
    logic        e_solved;

    function automatic logic [15:0] pal_rgb(input int c);
        case (c)
            0: return 16'hFFFF;
            1: return 16'hF800;
            2: return 16'h07E0;
            3: return 16'h001F;
            4: return 16'hFFE0;
            5: return 16'h07FF;
            6: return 16'hF81F;
            default: return 16'hFD20;
        endcase
    endfunction

    function automatic logic [15:0] model_pixel(input int idx);
        int x, y, top;
        logic [15:0] rgb;
        rgb = 16'h0000;
        if (idx > 6143) return 16'h0000;
        x = idx % 96;
        y = idx / 96;
        for (int i = 0; i <= NS; i++) begin
            top = SQ_Y0 + i * SQ_PITCH;
            if (x >= SQ_X0 && x < SQ_X0 + SQ_SIZE && y >= top && y < top + SQ_SIZE) begin
                if (i == NS)
                    rgb = m_solved ? 16'hF800 : 16'hFFFF;
                else if (i == m_cur && (x == SQ_X0 || x == SQ_X0 + SQ_SIZE - 1 ||
                                        y == top || y == top + SQ_SIZE - 1))
                    rgb = 16'hFFE0;
                else
                    rgb = pal_rgb(m_col[i]);
            end
        end
        return rgb;
    endfunction

    always @(posedge clk) begin
        bit all_match, up_e, dn_e, ce_e, lock;
        if (!reset_n) begin
            foreach (m_col[i]) m_col[i] = 0;
            m_cur = 0; m_cnt = 0; m_ph = 0; m_solved = 0;
            m_en_prev = 0; m_up_prev = 0; m_ce_prev = 0; m_dn_prev = 0;
            e_oled = '0; e_led = '0; e_solved = 1'b0;
        end else begin
            all_match = 1;
            foreach (m_col[i]) if (m_col[i] != 2) all_match = 0;
            e_solved = enable && all_match;
            e_led    = enable ? ((m_ph ? 16'h0265 : 16'h0000) | 16'h2000 | (e_solved ? 16'h8000 : 16'h0000))
                              : 16'h0000;
            e_oled   = enable ? model_pixel(int'(pixel_index)) : 16'h0000;
`ifdef COLOUR_PUZZLE_LOCK_EN
            lock = m_solved;
`else
            lock = 0;
`endif
            up_e = enable && btn_up     && !m_up_prev;
            dn_e = enable && btn_down   && !m_dn_prev;
            ce_e = enable && btn_centre && !m_ce_prev;
            if (enable && !m_en_prev) begin
                foreach (m_col[i]) m_col[i] = 0;
                m_cur = 0; m_cnt = 0; m_ph = 1;
            end else if (enable) begin
                if (ce_e && !lock) m_col[m_cur] = (m_col[m_cur] + 1) % NC;
                m_cur = (m_cur + NS + (dn_e ? 1 : 0) - (up_e ? 1 : 0)) % NS;
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_ph  = !m_ph;
                end else begin
                    m_cnt++;
                end
            end
            m_solved  = e_solved;
            m_en_prev = enable;
            m_up_prev = btn_up; m_ce_prev = btn_centre; m_dn_prev = btn_down;
        end
        #1;
        check("cycle_oled", oled_data, e_oled);
        check("cycle_led", led, e_led);
        check("cycle_solved", {15'b0, solved}, {15'b0, e_solved});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input bit ce, input bit dn, input int hold);
        btn_up = up; btn_centre = ce; btn_down = dn;
        tick(hold);
        btn_up = 0; btn_centre = 0; btn_down = 0;
        tick(1);
    endtask

    task automatic pix_check(input string name, input int x, input int y, input logic [15:0] exp);
        pixel_index = 13'(y * 96 + x);
        tick(1);
        check(name, oled_data, exp);
    endtask

    initial begin
        tick(3);
        check("reset_led", led, 16'h0000);
        check("reset_oled", oled_data, 16'h0000);
        check("reset_solved", {15'b0, solved}, 16'h0000);

        reset_n = 1; enable = 1;
        tick(1); check("blink_e0", led, 16'h2000);
        tick(1); check("blink_e1", led, 16'h2265);
        tick(3); check("blink_e4", led, 16'h2265);
        tick(1); check("blink_e5", led, 16'h2000);
        tick(4); check("blink_e9", led, 16'h2265);

        press(0, 1, 0, 1);
        press(0, 1, 0, 1);
        pix_check("sq0_green", 45, 7, 16'h07E0);
        pix_check("sq0_ring", 43, 5, 16'hFFE0);

        press(0, 0, 1, 1);
        pix_check("cur1_ring", 43, 20, 16'hFFE0);
        pix_check("sq0_no_ring", 43, 5, 16'h07E0);
        press(0, 0, 1, 1);
        pix_check("cur2_ring", 43, 35, 16'hFFE0);
        press(0, 0, 1, 1);
        pix_check("cur0_wrap", 43, 5, 16'hFFE0);
        press(1, 0, 0, 1);
        pix_check("up_wrap", 43, 35, 16'hFFE0);
        pix_check("offscreen", 0, 0, 16'h0000);
        pixel_index = 13'd8000; tick(1);
        check("beyond_6143", oled_data, 16'h0000);

        press(1, 1, 1, 3);
        pix_check("both_moves", 43, 35, 16'hFFE0);
        pix_check("held_once", 45, 37, 16'hF800);

        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(0, 1, 0, 1);
        tick(2);
        check("solved_set", {15'b0, solved}, 16'h0001);
        check("led15", {15'b0, led[15]}, 16'h0001);
        pix_check("status_red", 45, 52, 16'hF800);

        press(0, 1, 0, 1);
        tick(2);
`ifdef COLOUR_PUZZLE_LOCK_EN
        check("lock_solved", {15'b0, solved}, 16'h0001);
        pix_check("lock_colour", 45, 22, 16'h07E0);
`else
        check("unlock_solved", {15'b0, solved}, 16'h0000);
        pix_check("unlock_colour", 45, 22, 16'h001F);
`endif

        pixel_index = 13'(7 * 96 + 45);
        enable = 0;
        tick(2);
        check("dis_oled", oled_data, 16'h0000);
        check("dis_led", led, 16'h0000);
        check("dis_solved", {15'b0, solved}, 16'h0000);
        enable = 1;
        tick(3);
        pix_check("reentry_white", 45, 7, 16'hFFFF);
        pix_check("reentry_ring", 43, 5, 16'hFFE0);
        check("reentry_solved", {15'b0, solved}, 16'h0000);

        tick(2);
        #3 reset_n = 0;
        #1 check("async_led", led, 16'h0000);
        check("async_oled", oled_data, 16'h0000);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/colour_puzzle_panel.md
# colour_puzzle_panel

Parametrised colour-matching puzzle stage for the password-gated student screens. It renders NUM_SQUARES colour squares plus one status square on the 96x64 OLED and lets the user move a cursor with up/down and cycle the selected square's colour with centre. It raises `solved` when every square matches a compile-time target pattern, and drives blink/steady LED masks while the stage is enabled. It sits between the debounced button outputs and the top-level OLED/LED multiplexer.

## Interface
- NUM_SQUARES, 3: puzzle squares, 1..8.
- NUM_COLOURS, 4: palette entries used, 2..8.
- TARGET, {3'd2,3'd2,3'd2}: packed NUM_SQUARES×3-bit target; square i is at [3i+2:3i].
- SQ_X0 / SQ_Y0 / SQ_SIZE / SQ_PITCH, 43 / 5 / 10 / 15: square geometry in pixels.
- BLINK_DIV, 16_666_667: clock cycles per blink-phase toggle.
- BLINK_MASK / STEADY_MASK, 16'h0265 / 16'h2000: LED bits that blink / stay lit.
- clock_100mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  stage active (password level).
- btn_up, btn_centre, btn_down  in  1 each  debounced button levels.
- pixel_index  in  13  OLED pixel address, 0..6143.
- oled_data  out  16  RGB565 pixel, registered.
- led  out  16  LED drive, registered.
- solved  out  1  all squares equal TARGET, registered.

## Operation
- Coordinates: x = pixel_index % 96, y = pixel_index / 96. pixel_index > 6143 → black.
- Square i (0..NUM_SQUARES-1) spans x ∈ [SQ_X0, SQ_X0+SQ_SIZE) and y ∈ [SQ_Y0+i·SQ_PITCH, +SQ_SIZE). Its fill is palette[colour[i]].
- Status square uses index NUM_SQUARES: red when solved, white otherwise.
- Selected square: its outermost 1-pixel ring is drawn yellow. All other pixels are black.
- Palette: 0 white, 1 red, 2 green, 3 blue, 4 yellow, 5 cyan, 6 magenta, 7 orange.
- Button events: each button is rising-edge detected with a 1-cycle history register. Holding a button produces exactly one event.
- Up event: cursor − 1, wrapping from 0 to NUM_SQUARES−1. Down event: cursor + 1, wrapping from NUM_SQUARES−1 to 0.
- Up and down in the same cycle: cursor unchanged.
- Centre event: colour[cursor] + 1, wrapping from NUM_COLOURS−1 to 0.
- Centre together with a move in the same cycle: the colour change applies to the pre-move cursor.
- Entry: on an enable rising edge, all colours → 0, cursor → 0, blink counter → 0, blink phase → 1.
- enable low: buttons ignored, state held, oled_data = 0, led = 0, solved = 0.
- led (enable high) = (BLINK_MASK & {16{phase}}) | STEADY_MASK | (solved << 15).
- Reset (asynchronous, any time): colours, cursor, counter and all outputs → 0; phase → 0.

## Timing
- oled_data: 1-cycle latency from pixel_index. It reflects colour state from the previous cycle.
- Button edge to state update: 1 cycle after the level is first sampled high.
- State update to solved / led: +1 cycle. Status square follows solved with a further 1 cycle.
- Blink phase toggles on the cycle the counter reaches BLINK_DIV−1; the counter then returns to 0.

## Configuration
- COLOUR_PUZZLE_LOCK_EN defined: once solved = 1, centre events are ignored until the next enable rising edge. The cursor still moves.
- COLOUR_PUZZLE_LOCK_EN undefined: colours stay editable after solving, and solved falls as soon as the pattern breaks.

## Structure
- colour_puzzle_pkg holds:
  - the RGB565 palette constants (8 entries, plus BLACK, RED and YELLOW aliases);
  - COLOUR_W = 3;
  - OLED_W = 96, OLED_H = 64, OLED_PIXELS = 6144.
- Sub-module blink_divider (BLINK_DIV parameter; clear and enable inputs; phase output) generates the blink phase.
- A static check rejects geometry where SQ_Y0 + NUM_SQUARES·SQ_PITCH + SQ_SIZE > 64.

## Test plan
- Reset_n low then high, enable high, BLINK_DIV=4 → colours all 0; led toggles 16'h2265 / 16'h2000 every 4 cycles; solved = 0.
- Centre pressed twice on cursor 0 → pixel (45,7) reads green 16'h07E0 one cycle after pixel_index = 7·96+45; pixel (43,5) reads yellow.
- Down ×3 → cursor wraps 0→1→2→0. Up from 0 → cursor 2.
- All squares set to 2 → solved = 1, led[15] = 1, status pixel (45,52) = 16'hF800. With LOCK_EN, a further centre leaves the colours unchanged.
- Up and down in the same cycle together with centre → cursor unchanged; colour[cursor] incremented once; a held button causes no repeat.
- enable dropped then raised mid-puzzle → colours and cursor reset to 0. Reset_n asserted mid-blink → led = 0 immediately.
